// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one core RAM (one write port and one registered-address read port) between instruction
// fetch (IF, read-only) and the LSU (read/write). At most one RAM access is made per cycle. A read
// and a write never happen in the same cycle. LSU sub-word stores become a two-cycle
// read-modify-write.
//
// Ports
//   clk_i, rst_n_i                   clock, asynchronous active-low reset
//   if_req_i/if_addr_i/if_gnt_o      IF read request handshake (gnt combinational)
//   if_rvalid_o/if_rdata_o           IF read response, one cycle after grant
//   lsu_req_i/lsu_we_i/lsu_be_i/
//   lsu_addr_i/lsu_wdata_i/lsu_gnt_o LSU request handshake (gnt combinational)
//   lsu_rvalid_o/lsu_rdata_o         LSU load data or store completion (data 0 for stores)
//   ram_wen_o/ram_waddr_o/ram_wdata_o RAM write port (addr/data 0 when not writing)
//   ram_raddr_o/ram_rdata_i          RAM read port, data valid the cycle after capture
module ram_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [DATA_W/8-1:0] lsu_be_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                ram_wen_o,
  output logic [ADDR_W-1:0]   ram_waddr_o,
  output logic [DATA_W-1:0]   ram_wdata_o,
  output logic [ADDR_W-1:0]   ram_raddr_o,
  input  logic [DATA_W-1:0]   ram_rdata_i
);

  localparam int unsigned BeW = DATA_W / 8;

  typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

  state_e            state_q, state_d;
  logic              last_lsu_q, last_lsu_d;     // 1: most recent grant went to the LSU
  logic              if_rvalid_q, if_rvalid_d;
  logic              lsu_rvalid_q, lsu_rvalid_d;
  logic              lsu_store_q, lsu_store_d;   // pending LSU response is a store completion
  logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
  logic [DATA_W-1:0] rmw_wdata_q, rmw_wdata_d;
  logic [BeW-1:0]    rmw_be_q, rmw_be_d;

  logic              grant_if, grant_lsu;
  logic              be_full, be_none;
  logic [DATA_W-1:0] merged;

  assign be_full = &lsu_be_i;
  assign be_none = ~|lsu_be_i;

  // Byte merge of the latched store over the word read in the previous cycle.
  always_comb begin
    merged = '0;
    for (int b = 0; b < BeW; b++) begin
      merged[b*8 +: 8] = rmw_be_q[b] ? rmw_wdata_q[b*8 +: 8] : ram_rdata_i[b*8 +: 8];
    end
  end

  // Arbitration; grants only in IDLE and never while reset is asserted.
  always_comb begin
    grant_if  = 1'b0;
    grant_lsu = 1'b0;
    if (rst_n_i && (state_q == StIdle)) begin
      if (if_req_i && lsu_req_i) begin
        if (ARB_MODE == 32'd0) begin
          grant_lsu = 1'b1;
        end else begin
          grant_lsu = ~last_lsu_q;
          grant_if  = last_lsu_q;
        end
      end else begin
        grant_if  = if_req_i;
        grant_lsu = lsu_req_i;
      end
    end
  end

  assign if_gnt_o  = grant_if;
  assign lsu_gnt_o = grant_lsu;

  always_comb begin
    state_d      = state_q;
    last_lsu_d   = last_lsu_q;
    if_rvalid_d  = grant_if;
    lsu_rvalid_d = 1'b0;
    lsu_store_d  = lsu_store_q;
    rmw_addr_d   = rmw_addr_q;
    rmw_wdata_d  = rmw_wdata_q;
    rmw_be_d     = rmw_be_q;
    ram_wen_o    = 1'b0;
    ram_waddr_o  = '0;
    ram_wdata_o  = '0;
    ram_raddr_o  = if_addr_i;

    unique case (state_q)
      StIdle: begin
        if (grant_if) begin
          last_lsu_d = 1'b0;
        end
        if (grant_lsu) begin
          last_lsu_d  = 1'b1;
          lsu_store_d = lsu_we_i;
          if (!lsu_we_i) begin
            ram_raddr_o  = lsu_addr_i;
            lsu_rvalid_d = 1'b1;
          end else if (be_full) begin
            ram_wen_o    = 1'b1;
            ram_waddr_o  = lsu_addr_i;
            ram_wdata_o  = lsu_wdata_i;
            lsu_rvalid_d = 1'b1;
          end else if (be_none) begin
            lsu_rvalid_d = 1'b1;
          end else begin
            // Partial store: fetch the old word now, write the merge next cycle.
            ram_raddr_o = lsu_addr_i;
            rmw_addr_d  = lsu_addr_i;
            rmw_wdata_d = lsu_wdata_i;
            rmw_be_d    = lsu_be_i;
            state_d     = StRmwWr;
          end
        end
      end
      StRmwWr: begin
        ram_wen_o    = 1'b1;
        ram_waddr_o  = rmw_addr_q;
        ram_wdata_o  = merged;
        lsu_rvalid_d = 1'b1;
        lsu_store_d  = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      last_lsu_q   <= 1'b0;
      if_rvalid_q  <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      lsu_store_q  <= 1'b0;
      rmw_addr_q   <= '0;
      rmw_wdata_q  <= '0;
      rmw_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_lsu_q   <= last_lsu_d;
      if_rvalid_q  <= if_rvalid_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_store_q  <= lsu_store_d;
      rmw_addr_q   <= rmw_addr_d;
      rmw_wdata_q  <= rmw_wdata_d;
      rmw_be_q     <= rmw_be_d;
    end
  end

  assign if_rvalid_o  = if_rvalid_q;
  assign if_rdata_o   = if_rvalid_q ? ram_rdata_i : '0;
  assign lsu_rvalid_o = lsu_rvalid_q;
  assign lsu_rdata_o  = (lsu_rvalid_q && !lsu_store_q) ? ram_rdata_i : '0;

endmodule
